// File: rtl/reg_dump_pkg.sv
// rtl/reg_dump_pkg.sv - shared types and widths for the register dump checker
package reg_dump_pkg;

  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;
  localparam int CNT_W     = 4;
  localparam int FAIL_W    = 6;
  localparam int NUM_REGS  = 1 << REG_IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

endpackage

// File: rtl/reg_expect_table.sv
// rtl/reg_expect_table.sv - expected-value table with per-entry check enables
module reg_expect_table
  import reg_dump_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_we,
  input  logic                 i_clr,
  input  logic [REG_IDX_W-1:0] i_waddr,
  input  logic [DATA_W-1:0]    i_wdata,
  input  logic [REG_IDX_W-1:0] i_raddr,
  output logic [DATA_W-1:0]    o_rd_data,
  output logic                 o_rd_en
);

  logic [DATA_W-1:0]   r_data [NUM_REGS];
  logic [NUM_REGS-1:0] r_en;
  logic [NUM_REGS-1:0] w_wr_onehot;

  assign w_wr_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << i_waddr;

  // Expected values are plain storage; they survive reset, only the enables are cleared
  always_ff @(posedge clk) begin
    if (i_we) r_data[i_waddr] <= i_wdata;
  end

  // Enable bits: a clear applies before a same-cycle write, so the written entry stays enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en <= '0;
    end else if (i_clr) begin
      r_en <= i_we ? w_wr_onehot : '0;
    end else if (i_we) begin
      r_en <= r_en | w_wr_onehot;
    end
  end

  assign o_rd_data = r_data[i_raddr];
  assign o_rd_en   = r_en[i_raddr];

endmodule

// File: rtl/reg_dump_checker.sv
// rtl/reg_dump_checker.sv - walks the CPU register monitor, dumps and checks each register
module reg_dump_checker
  import reg_dump_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int FIRST_REG     = 0,
  parameter int LAST_REG      = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [REG_IDX_W-1:0] reg_sel,
  input  logic [DATA_W-1:0]    reg_data,
  input  logic                 exp_we,
  input  logic [REG_IDX_W-1:0] exp_addr,
  input  logic [DATA_W-1:0]    exp_data,
  input  logic                 exp_clr,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [FAIL_W-1:0]    fail_count,
  output logic [REG_IDX_W-1:0] first_fail_idx,
  output logic [DATA_W-1:0]    first_fail_data,
  output logic                 dump_valid,
  output logic [REG_IDX_W-1:0] dump_idx,
  output logic [DATA_W-1:0]    dump_data
);

  localparam logic [CNT_W-1:0]     SETTLE_INIT = (SETTLE_CYCLES == 0) ? '0 : CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [REG_IDX_W-1:0] FIRST_IDX   = REG_IDX_W'(FIRST_REG);
  localparam logic [REG_IDX_W-1:0] LAST_IDX    = REG_IDX_W'(LAST_REG);
  // With no settle time the index change is followed directly by sampling
  localparam state_t               ST_AFTER_SEL = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [REG_IDX_W-1:0] r_idx;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_pass;
  logic [FAIL_W-1:0]    r_fail_count;
  logic [REG_IDX_W-1:0] r_first_fail_idx;
  logic [DATA_W-1:0]    r_first_fail_data;
  logic                 r_dump_valid;
  logic [REG_IDX_W-1:0] r_dump_idx;
  logic [DATA_W-1:0]    r_dump_data;

  logic                 w_tbl_we;
  logic                 w_tbl_clr;
  logic [DATA_W-1:0]    w_exp_data;
  logic                 w_exp_en;
  logic                 w_mismatch;

  // Table is frozen while a scan runs
  assign w_tbl_we  = exp_we & ~r_busy;
  assign w_tbl_clr = exp_clr & ~r_busy;

  reg_expect_table u_table (
    .clk       (clk),
    .rst_n     (rst),
    .i_we      (w_tbl_we),
    .i_clr     (w_tbl_clr),
    .i_waddr   (exp_addr),
    .i_wdata   (exp_data),
    .i_raddr   (r_idx),
    .o_rd_data (w_exp_data),
    .o_rd_en   (w_exp_en)
  );

  assign w_mismatch = w_exp_en && (reg_data != w_exp_data);

  // Scan sequencer: select, settle, sample, and accumulate the check results
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state           <= IDLE;
      r_cnt             <= '0;
      r_idx             <= '0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_pass            <= 1'b0;
      r_fail_count      <= '0;
      r_first_fail_idx  <= '0;
      r_first_fail_data <= '0;
      r_dump_valid      <= 1'b0;
      r_dump_idx        <= '0;
      r_dump_data       <= '0;
    end else begin
      r_done       <= 1'b0;
      r_dump_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_idx             <= FIRST_IDX;
            r_fail_count      <= '0;
            r_first_fail_idx  <= '0;
            r_first_fail_data <= '0;
            r_pass            <= 1'b0;
            r_busy            <= 1'b1;
            r_cnt             <= SETTLE_INIT;
            r_state           <= ST_AFTER_SEL;
          end
        end
        SETTLE: begin
          if (r_cnt == '0) r_state <= SAMPLE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        SAMPLE: begin
          r_dump_valid <= 1'b1;
          r_dump_idx   <= r_idx;
          r_dump_data  <= reg_data;
          if (w_mismatch) begin
            r_fail_count <= r_fail_count + 1'b1;
            if (r_fail_count == '0) begin
              r_first_fail_idx  <= r_idx;
              r_first_fail_data <= reg_data;
            end
          end
          if (r_idx == LAST_IDX) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_cnt   <= SETTLE_INIT;
            r_state <= ST_AFTER_SEL;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_pass  <= (r_fail_count == '0);
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign reg_sel         = r_idx;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign fail_count      = r_fail_count;
  assign first_fail_idx  = r_first_fail_idx;
  assign first_fail_data = r_first_fail_data;
  assign dump_valid      = r_dump_valid;
  assign dump_idx        = r_dump_idx;
  assign dump_data       = r_dump_data;

endmodule
